execute: RTL and testbench

EXECUTE -- requirements
Module: execute

---
 rtl/nebula_pkg.sv | 46 ++++
 rtl/execute_alu.sv | 52 +++++
 rtl/execute.sv | 190 +++++++++++++++++++
 tb/tb_execute.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nebula_pkg.sv
// Shared types for the nebula execute stage: data word, ALU/branch opcodes, FSM states.
package nebula;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B,
    ALU_MUL
  } alu_op_t;

  typedef enum logic [3:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLT,
    BR_BGE,
    BR_BLTU,
    BR_BGEU,
    BR_JAL,
    BR_JALR
  } branch_op_t;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_MUL,
    EX_DONE
  } ex_state_t;

  function automatic logic is_jump(branch_op_t op);
    return (op == BR_JAL) || (op == BR_JALR);
  endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU and branch comparator for the execute stage.
module alu
  import nebula::*;
(
  input  alu_op_t    i_op,
  input  word_t      i_a,
  input  word_t      i_b,
  input  word_t      i_rs1,
  input  word_t      i_rs2,
  input  branch_op_t i_branch_op,
  output word_t      o_result,
  output logic       o_taken
);

  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:    o_result = i_a + i_b;
      ALU_SUB:    o_result = i_a - i_b;
      ALU_SLL:    o_result = i_a << w_shamt;
      ALU_SLT:    o_result = word_t'($signed(i_a) < $signed(i_b));
      ALU_SLTU:   o_result = word_t'(i_a < i_b);
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_SRL:    o_result = i_a >> w_shamt;
      ALU_SRA:    o_result = word_t'($signed(i_a) >>> w_shamt);
      ALU_OR:     o_result = i_a | i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_PASS_B: o_result = i_b;
      default:    o_result = '0;
    endcase
  end

  // Branches compare the raw register operands regardless of operand selects.
  always_comb begin
    o_taken = 1'b0;
    case (i_branch_op)
      BR_BEQ:  o_taken = (i_rs1 == i_rs2);
      BR_BNE:  o_taken = (i_rs1 != i_rs2);
      BR_BLT:  o_taken = ($signed(i_rs1) < $signed(i_rs2));
      BR_BGE:  o_taken = ($signed(i_rs1) >= $signed(i_rs2));
      BR_BLTU: o_taken = (i_rs1 < i_rs2);
      BR_BGEU: o_taken = (i_rs1 >= i_rs2);
      BR_JAL:  o_taken = 1'b1;
      BR_JALR: o_taken = 1'b1;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU/branch results plus an optional iterative multiplier
// (enabled by NEBULA_MUL_EN; otherwise MUL retires immediately as illegal).
module execute
  import nebula::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  word_t             pc_i,
  input  word_t             rs1_i,
  input  word_t             rs2_i,
  input  word_t             imm_i,
  input  alu_op_t           alu_op_i,
  input  branch_op_t        branch_op_i,
  input  logic              a_sel_pc_i,
  input  logic              b_sel_imm_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_we_i,
  output logic              valid_o,
  input  logic              ready_i,
  output word_t             result_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              rd_we_o,
  output logic              illegal_o,
  output logic              redirect_o,
  output word_t             redirect_pc_o
);

  if (!(MUL_BITS_PER_CYCLE inside {32'd1, 32'd2, 32'd4, 32'd8})) begin : g_bad_mul_cfg
    $error("execute: MUL_BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  ex_state_t         r_state;
  logic              r_valid;
  logic              r_redirect;
  logic              r_rd_we;
  logic              r_illegal;
  word_t             r_result;
  logic [REG_AW-1:0] r_rd_addr;
  word_t             r_redirect_pc;

  word_t w_op_a;
  word_t w_op_b;
  word_t w_alu_res;
  word_t w_target;
  logic  w_taken;
  logic  w_jump;
  logic  w_accept;
  logic  w_start_mul;
  logic  w_illegal;

  assign w_op_a = a_sel_pc_i  ? pc_i  : rs1_i;
  assign w_op_b = b_sel_imm_i ? imm_i : rs2_i;

  alu u_alu (
    .i_op        (alu_op_i),
    .i_a         (w_op_a),
    .i_b         (w_op_b),
    .i_rs1       (rs1_i),
    .i_rs2       (rs2_i),
    .i_branch_op (branch_op_i),
    .o_result    (w_alu_res),
    .o_taken     (w_taken)
  );

  assign w_jump   = is_jump(branch_op_i);
  assign w_target = (branch_op_i == BR_JALR) ? ((rs1_i + imm_i) & ~word_t'(1))
                                             : (pc_i + imm_i);

  assign ready_o  = !rst_i && (r_state == EX_IDLE) && (!r_valid || ready_i) && !flush_i;
  assign w_accept = valid_i && ready_o;

`ifdef NEBULA_MUL_EN
  localparam int unsigned MUL_STEPS = 32 / MUL_BITS_PER_CYCLE;
  localparam int unsigned CNT_W     = 6;

  logic [CNT_W-1:0]  r_mul_cnt;
  word_t             r_mul_a;
  word_t             r_mul_b;
  word_t             r_mul_acc;
  logic [REG_AW-1:0] r_mul_rd;
  logic              r_mul_we;
  word_t             w_mul_acc_nxt;

  assign w_start_mul = w_accept && (alu_op_i == ALU_MUL);
  assign w_illegal   = 1'b0;

  // Shift-and-add over MUL_BITS_PER_CYCLE multiplier bits per step.
  always_comb begin
    w_mul_acc_nxt = r_mul_acc;
    for (int i = 0; i < int'(MUL_BITS_PER_CYCLE); i++) begin
      if (r_mul_b[i]) w_mul_acc_nxt = w_mul_acc_nxt + (r_mul_a << i);
    end
  end
`else
  assign w_start_mul = 1'b0;
  assign w_illegal   = (alu_op_i == ALU_MUL);
`endif

  // Later assignments override earlier ones; flush is last so it wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= EX_IDLE;
      r_valid       <= 1'b0;
      r_redirect    <= 1'b0;
      r_rd_we       <= 1'b0;
      r_illegal     <= 1'b0;
      r_result      <= '0;
      r_rd_addr     <= '0;
      r_redirect_pc <= '0;
`ifdef NEBULA_MUL_EN
      r_mul_cnt     <= '0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_acc     <= '0;
      r_mul_rd      <= '0;
      r_mul_we      <= 1'b0;
`endif
    end else begin
      r_redirect <= 1'b0;
      if (ready_i) r_valid <= 1'b0;

      if (w_accept && !w_start_mul) begin
        r_valid       <= 1'b1;
        r_result      <= w_illegal ? '0 : (w_jump ? (pc_i + word_t'(4)) : w_alu_res);
        r_rd_addr     <= rd_addr_i;
        r_rd_we       <= rd_we_i && !w_illegal;
        r_illegal     <= w_illegal;
        r_redirect    <= w_taken && !w_illegal;
        r_redirect_pc <= w_target;
      end

`ifdef NEBULA_MUL_EN
      case (r_state)
        EX_IDLE: begin
          if (w_start_mul) begin
            r_mul_a   <= rs1_i;
            r_mul_b   <= rs2_i;
            r_mul_acc <= '0;
            r_mul_rd  <= rd_addr_i;
            r_mul_we  <= rd_we_i;
            r_mul_cnt <= CNT_W'(MUL_STEPS);
            r_state   <= EX_MUL;
          end
        end
        EX_MUL: begin
          r_mul_acc <= w_mul_acc_nxt;
          r_mul_a   <= r_mul_a << MUL_BITS_PER_CYCLE;
          r_mul_b   <= r_mul_b >> MUL_BITS_PER_CYCLE;
          r_mul_cnt <= r_mul_cnt - CNT_W'(1);
          if (r_mul_cnt == CNT_W'(1)) r_state <= EX_DONE;
        end
        EX_DONE: begin
          if (!r_valid || ready_i) begin
            r_valid   <= 1'b1;
            r_result  <= r_mul_acc;
            r_rd_addr <= r_mul_rd;
            r_rd_we   <= r_mul_we;
            r_illegal <= 1'b0;
            r_state   <= EX_IDLE;
          end
        end
        default: r_state <= EX_IDLE;
      endcase
`endif

      if (flush_i) begin
        r_valid    <= 1'b0;
        r_redirect <= 1'b0;
        r_state    <= EX_IDLE;
`ifdef NEBULA_MUL_EN
        r_mul_cnt  <= '0;
`endif
      end
    end
  end

  assign valid_o       = r_valid;
  assign redirect_o    = r_redirect;
  assign rd_we_o       = r_rd_we;
  assign illegal_o     = r_illegal;
  assign result_o      = r_result;
  assign rd_addr_o     = r_rd_addr;
  assign redirect_pc_o = r_redirect_pc;

endmodule

// File: tb/tb_execute.sv
// Directed, table-driven bench for the execute stage (covers both NEBULA_MUL_EN builds).
module tb_execute;
  import nebula::*;

  localparam int unsigned TB_MBPC   = 1;
  localparam int unsigned MUL_LAT   = 32 / TB_MBPC + 1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  word_t       pc_i, rs1_i, rs2_i, imm_i;
  alu_op_t     alu_op_i;
  branch_op_t  branch_op_i;
  logic        a_sel_pc_i, b_sel_imm_i;
  logic [4:0]  rd_addr_i;
  logic        rd_we_i;
  logic        valid_o;
  logic        ready_i;
  word_t       result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o, illegal_o, redirect_o;
  word_t       redirect_pc_o;

  execute #(.MUL_BITS_PER_CYCLE(TB_MBPC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .alu_op_i(alu_op_i), .branch_op_i(branch_op_i), .a_sel_pc_i(a_sel_pc_i),
    .b_sel_imm_i(b_sel_imm_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .rd_addr_o(rd_addr_o),
    .rd_we_o(rd_we_o), .illegal_o(illegal_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    alu_op_t    op;
    branch_op_t br;
    logic       a_pc;
    logic       b_imm;
    word_t      pc, rs1, rs2, imm;
    logic [4:0] rd;
    logic       we;
    logic       chk_res;
    word_t      res;
    logic       redir;
    word_t      tgt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addv(input string n, input alu_op_t op, input branch_op_t br,
                      input logic a_pc, input logic b_imm, input word_t pc, input word_t rs1,
                      input word_t rs2, input word_t imm, input logic [4:0] rd, input logic we,
                      input logic chk_res, input word_t res, input logic redir, input word_t tgt);
    vec_t v;
    v.name = n; v.op = op; v.br = br; v.a_pc = a_pc; v.b_imm = b_imm;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.rd = rd; v.we = we;
    v.chk_res = chk_res; v.res = res; v.redir = redir; v.tgt = tgt;
    vecs.push_back(v);
  endtask

  // Waits (bounded) for ready_o, presents one instruction, returns at the negedge after acceptance.
  task automatic issue(input alu_op_t op, input branch_op_t br, input logic a_pc,
                       input logic b_imm, input word_t pc, input word_t rs1, input word_t rs2,
                       input word_t imm, input logic [4:0] rd, input logic we);
    int k;
    k = 0;
    @(negedge clk_i);
    while (!ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (!ready_o) check("issue_ready_timeout", word_t'(ready_o), 32'd1);
    alu_op_i = op; branch_op_i = br; a_sel_pc_i = a_pc; b_sel_imm_i = b_imm;
    pc_i = pc; rs1_i = rs1; rs2_i = rs2; imm_i = imm; rd_addr_i = rd; rd_we_i = we;
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    logic saw_valid;

    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    alu_op_i = ALU_ADD; branch_op_i = BR_NONE; a_sel_pc_i = 1'b0; b_sel_imm_i = 1'b0;
    rd_addr_i = '0; rd_we_i = 1'b0;

    //     name      op          br       apc bimm pc          rs1         rs2         imm         rd we chk res          rdr tgt
    addv("ADD",    ALU_ADD,    BR_NONE, 0, 0, 32'h0,      32'hFFFFFFFF, 32'h1,     32'h0,      5'd5, 1, 1, 32'h00000000, 0, 32'h0);
    addv("SUB",    ALU_SUB,    BR_NONE, 0, 0, 32'h0,      32'h5,      32'h7,       32'h0,      5'd6, 1, 1, 32'hFFFFFFFE, 0, 32'h0);
    addv("SLL",    ALU_SLL,    BR_NONE, 0, 0, 32'h0,      32'h1,      32'h21,      32'h0,      5'd7, 1, 1, 32'h00000002, 0, 32'h0);
    addv("SLT",    ALU_SLT,    BR_NONE, 0, 0, 32'h0,      32'hFFFFFFFF, 32'h1,     32'h0,      5'd8, 1, 1, 32'h00000001, 0, 32'h0);
    addv("SLTU",   ALU_SLTU,   BR_NONE, 0, 0, 32'h0,      32'hFFFFFFFF, 32'h1,     32'h0,      5'd9, 1, 1, 32'h00000000, 0, 32'h0);
    addv("XOR",    ALU_XOR,    BR_NONE, 0, 0, 32'h0,      32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   5'd10, 1, 1, 32'h0FF00FF0, 0, 32'h0);
    addv("SRL",    ALU_SRL,    BR_NONE, 0, 0, 32'h0,      32'h80000000, 32'h4,     32'h0,      5'd11, 1, 1, 32'h08000000, 0, 32'h0);
    addv("SRA",    ALU_SRA,    BR_NONE, 0, 0, 32'h0,      32'h80000000, 32'h4,     32'h0,      5'd12, 1, 1, 32'hF8000000, 0, 32'h0);
    addv("OR",     ALU_OR,     BR_NONE, 0, 0, 32'h0,      32'h0F,     32'hF0,      32'h0,      5'd13, 1, 1, 32'h000000FF, 0, 32'h0);
    addv("AND",    ALU_AND,    BR_NONE, 0, 0, 32'h0,      32'h0FF0,   32'h00FF,    32'h0,      5'd14, 1, 1, 32'h000000F0, 0, 32'h0);
    addv("PASS_B", ALU_PASS_B, BR_NONE, 0, 1, 32'h0,      32'h0,      32'h0,       32'h12345000, 5'd15, 1, 1, 32'h12345000, 0, 32'h0);
    addv("AUIPC",  ALU_ADD,    BR_NONE, 1, 1, 32'h1000,   32'h0,      32'h0,       32'h10,     5'd16, 1, 1, 32'h00001010, 0, 32'h0);
    addv("BLT",    ALU_ADD,    BR_BLT,  0, 0, 32'h100,    32'hFFFFFFFE, 32'h1,     32'h20,     5'd0, 0, 0, 32'h0, 1, 32'h120);
    addv("BLTU",   ALU_ADD,    BR_BLTU, 0, 0, 32'h100,    32'hFFFFFFFE, 32'h1,     32'h20,     5'd0, 0, 0, 32'h0, 0, 32'h0);
    addv("BEQ",    ALU_ADD,    BR_BEQ,  0, 0, 32'h200,    32'h7,      32'h7,       32'h40,     5'd0, 0, 0, 32'h0, 1, 32'h240);
    addv("BNE",    ALU_ADD,    BR_BNE,  0, 0, 32'h200,    32'h7,      32'h7,       32'h40,     5'd0, 0, 0, 32'h0, 0, 32'h0);
    addv("BGE",    ALU_ADD,    BR_BGE,  0, 0, 32'h300,    32'hFFFFFFFF, 32'h1,     32'h8,      5'd0, 0, 0, 32'h0, 0, 32'h0);
    addv("BGEU",   ALU_ADD,    BR_BGEU, 0, 0, 32'h300,    32'hFFFFFFFF, 32'h1,     32'h8,      5'd0, 0, 0, 32'h0, 1, 32'h308);
    addv("JALR",   ALU_ADD,    BR_JALR, 0, 1, 32'h40,     32'h203,    32'h0,       32'h0,      5'd1, 1, 1, 32'h44, 1, 32'h202);
    addv("JAL",    ALU_ADD,    BR_JAL,  1, 1, 32'h80,     32'h0,      32'h0,       32'h100,    5'd1, 1, 1, 32'h84, 1, 32'h180);

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst.ready_o",     word_t'(ready_o),    32'd0);
    check("rst.valid_o",     word_t'(valid_o),    32'd0);
    check("rst.redirect_o",  word_t'(redirect_o), 32'd0);
    check("rst.rd_we_o",     word_t'(rd_we_o),    32'd0);
    check("rst.illegal_o",   word_t'(illegal_o),  32'd0);
    check("rst.result_o",    result_o,            32'd0);
    check("rst.rd_addr_o",   word_t'(rd_addr_o),  32'd0);
    check("rst.redirect_pc", redirect_pc_o,       32'd0);
    rst_i = 1'b0;

    // Single-cycle table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].br, vecs[i].a_pc, vecs[i].b_imm, vecs[i].pc,
            vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].rd, vecs[i].we);
      check({vecs[i].name, ".valid"},    word_t'(valid_o),    32'd1);
      check({vecs[i].name, ".rd_we"},    word_t'(rd_we_o),    word_t'(vecs[i].we));
      check({vecs[i].name, ".rd_addr"},  word_t'(rd_addr_o),  word_t'(vecs[i].rd));
      check({vecs[i].name, ".illegal"},  word_t'(illegal_o),  32'd0);
      check({vecs[i].name, ".redirect"}, word_t'(redirect_o), word_t'(vecs[i].redir));
      if (vecs[i].chk_res) check({vecs[i].name, ".result"}, result_o, vecs[i].res);
      if (vecs[i].redir) begin
        check({vecs[i].name, ".target"}, redirect_pc_o, vecs[i].tgt);
        @(negedge clk_i);
        check({vecs[i].name, ".redirect_pulse"}, word_t'(redirect_o), 32'd0);
      end
    end

    // Backpressure: output held for 5 cycles, next instruction accepted on release
    @(negedge clk_i);
    check("drain.valid", word_t'(valid_o), 32'd0);
    ready_i = 1'b0;
    issue(ALU_ADD, BR_NONE, 1'b0, 1'b0, 32'h0, 32'd2, 32'd3, 32'h0, 5'd2, 1'b1);
    alu_op_i = ALU_ADD; rs1_i = 32'd10; rs2_i = 32'd20; rd_addr_i = 5'd3; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp.valid",   word_t'(valid_o),   32'd1);
      check("bp.result",  result_o,           32'd5);
      check("bp.rd_addr", word_t'(rd_addr_o), 32'd2);
      check("bp.ready_o", word_t'(ready_o),   32'd0);
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    #1;
    check("bp.release_ready", word_t'(ready_o), 32'd1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    check("bp.next_result",  result_o,           32'd30);
    check("bp.next_rd_addr", word_t'(rd_addr_o), 32'd3);
    check("bp.next_valid",   word_t'(valid_o),   32'd1);

    // Flush blocks a presented instruction
    @(negedge clk_i);
    alu_op_i = ALU_ADD; rs1_i = 32'd1; rs2_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    #1;
    check("flush.ready_o", word_t'(ready_o), 32'd0);
    @(negedge clk_i);
    check("flush.no_accept", word_t'(valid_o), 32'd0);
    valid_i = 1'b0; flush_i = 1'b0;

    // Flush beats a stalled output
    ready_i = 1'b0;
    issue(ALU_ADD, BR_NONE, 1'b0, 1'b0, 32'h0, 32'd4, 32'd4, 32'h0, 5'd4, 1'b1);
    check("flush_held.valid_before", word_t'(valid_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_held.valid_after", word_t'(valid_o), 32'd0);
    flush_i = 1'b0; ready_i = 1'b1;

`ifdef NEBULA_MUL_EN
    issue(ALU_MUL, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h12345678, 32'h10, 32'h0, 5'd9, 1'b1);
    cnt = 0;
    while (!ready_o && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
    end
    check("mul.ready_low_cycles", word_t'(cnt), word_t'(MUL_LAT));
    check("mul.valid",   word_t'(valid_o),   32'd1);
    check("mul.result",  result_o,           32'h23456780);
    check("mul.rd_addr", word_t'(rd_addr_o), 32'd9);
    check("mul.rd_we",   word_t'(rd_we_o),   32'd1);
    check("mul.illegal", word_t'(illegal_o), 32'd0);

    issue(ALU_MUL, BR_NONE, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd8, 1'b1);
    cnt = 0;
    while (!valid_o && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
    end
    check("mul_ff.result", result_o, 32'h00000001);

    // Flush mid-multiply
    issue(ALU_MUL, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h12345678, 32'h10, 32'h0, 5'd9, 1'b1);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("mul_flush.valid", word_t'(valid_o), 32'd0);
    check("mul_flush.ready", word_t'(ready_o), 32'd1);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) saw_valid = 1'b1;
    end
    check("mul_flush.no_late_result", word_t'(saw_valid), 32'd0);

    // Reset mid-multiply
    issue(ALU_MUL, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h3, 32'h5, 32'h0, 5'd9, 1'b1);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mul_rst.ready_in_reset", word_t'(ready_o), 32'd0);
    rst_i = 1'b0;
    #1;
    check("mul_rst.ready", word_t'(ready_o), 32'd1);
    check("mul_rst.valid", word_t'(valid_o), 32'd0);
`else
    issue(ALU_MUL, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h12345678, 32'h10, 32'h0, 5'd9, 1'b1);
    check("mul_ill.valid",   word_t'(valid_o),   32'd1);
    check("mul_ill.illegal", word_t'(illegal_o), 32'd1);
    check("mul_ill.rd_we",   word_t'(rd_we_o),   32'd0);
    check("mul_ill.result",  result_o,           32'd0);
    check("mul_ill.rd_addr", word_t'(rd_addr_o), 32'd9);
    cnt = 0;
    saw_valid = 1'b0;
    @(negedge clk_i);
    check("mul_ill.ready_after", word_t'(ready_o), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
